// File: rtl/conv_layer_sched.sv
// Per-layer sequencer for the convolution unit: bias once, then per group weights, pixel stream, drain.
// Latency: all outputs registered; min layer = 1 + groups*(1 + w*h + DRAIN_CYCLES) + 1 cycles after start.
// Backpressure: req outputs held until ack; pixel counters advance only on conv_valid_in while pix_ready.
module conv_layer_sched #(
    parameter int W_WIDTH      = 9,
    parameter int H_WIDTH      = 9,
    parameter int G_WIDTH      = 4,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic [W_WIDTH-1:0] cfg_img_w,
    input  logic [H_WIDTH-1:0] cfg_img_h,
    input  logic [G_WIDTH-1:0] cfg_groups,
    input  logic [3:0]         cfg_scale,
    output logic               bias_req,
    input  logic               bias_ack,
    output logic               wgt_req,
    input  logic               wgt_ack,
    output logic               pix_ready,
    input  logic               conv_valid_in,
    output logic [2:0]         current_state,
    output logic               adder_rst,
    output logic [3:0]         scale_out,
    output logic               out_en,
    output logic [G_WIDTH-1:0] group_idx,
    output logic [H_WIDTH-1:0] row_idx,
    output logic [W_WIDTH-1:0] col_idx,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD_BIAS = 3'd1;
    localparam logic [2:0] S_LOAD_WGT  = 3'd2;
    localparam logic [2:0] S_CONV      = 3'd3;
    localparam logic [2:0] S_DRAIN     = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    logic [2:0]         state_q, state_nxt;
    logic [W_WIDTH-1:0] img_w_q, img_w_nxt, col_q, col_nxt;
    logic [H_WIDTH-1:0] img_h_q, img_h_nxt, row_q, row_nxt;
    logic [G_WIDTH-1:0] groups_q, groups_nxt, group_q, group_nxt;
    logic [3:0]         scale_q, scale_nxt;
    logic [DW-1:0]      drain_q, drain_nxt;

    logic bias_req_d, wgt_req_d, pix_ready_d, adder_rst_d, out_en_d, busy_d, done_d;
    logic beat, col_last, row_last, last_beat, drain_last, group_last;

    assign beat       = (state_q == S_CONV) && conv_valid_in;
    assign col_last   = (col_q == img_w_q - W_WIDTH'(1));
    assign row_last   = (row_q == img_h_q - H_WIDTH'(1));
    assign last_beat  = beat && col_last && row_last;
    assign drain_last = (drain_q == DW'(DRAIN_CYCLES - 1));
    assign group_last = (group_q == groups_q - G_WIDTH'(1));

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:      if (start)      state_nxt = S_LOAD_BIAS;
            S_LOAD_BIAS: if (bias_ack)   state_nxt = S_LOAD_WGT;
            S_LOAD_WGT:  if (wgt_ack)    state_nxt = S_CONV;
            S_CONV:      if (last_beat)  state_nxt = S_DRAIN;
            S_DRAIN:     if (drain_last) state_nxt = group_last ? S_DONE : S_LOAD_WGT;
            S_DONE:                      state_nxt = S_IDLE;
            default:                     state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    // Counters and latched geometry; zero-sized dimensions are promoted to 1 at start.
    always_comb begin
        img_w_nxt  = img_w_q;
        img_h_nxt  = img_h_q;
        groups_nxt = groups_q;
        scale_nxt  = scale_q;
        col_nxt    = col_q;
        row_nxt    = row_q;
        group_nxt  = group_q;
        drain_nxt  = '0;
        if (state_q == S_IDLE && state_nxt == S_LOAD_BIAS) begin
            img_w_nxt  = (cfg_img_w  == '0) ? W_WIDTH'(1) : cfg_img_w;
            img_h_nxt  = (cfg_img_h  == '0) ? H_WIDTH'(1) : cfg_img_h;
            groups_nxt = (cfg_groups == '0) ? G_WIDTH'(1) : cfg_groups;
            scale_nxt  = cfg_scale;
            col_nxt    = '0;
            row_nxt    = '0;
            group_nxt  = '0;
        end
        if (beat && !abort) begin
            if (col_last) begin
                col_nxt = '0;
                row_nxt = row_q + H_WIDTH'(1);
            end else begin
                col_nxt = col_q + W_WIDTH'(1);
            end
        end
        if (state_q == S_DRAIN) begin
            drain_nxt = drain_q + DW'(1);
            if (state_nxt == S_LOAD_WGT) begin
                group_nxt = group_q + G_WIDTH'(1);
                row_nxt   = '0;
                col_nxt   = '0;
            end
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        bias_req_d  = (state_nxt == S_LOAD_BIAS);
        wgt_req_d   = (state_nxt == S_LOAD_WGT);
        pix_ready_d = (state_nxt == S_CONV);
        adder_rst_d = (state_q == S_IDLE) && (state_nxt == S_LOAD_BIAS);
        out_en_d    = ((state_nxt == S_CONV) || (state_nxt == S_DRAIN)) &&
                      (group_nxt == groups_nxt - G_WIDTH'(1));
        busy_d      = (state_nxt != S_IDLE);
        done_d      = (state_nxt == S_DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            img_w_q   <= '0;
            img_h_q   <= '0;
            groups_q  <= '0;
            scale_q   <= '0;
            col_q     <= '0;
            row_q     <= '0;
            group_q   <= '0;
            drain_q   <= '0;
            bias_req  <= 1'b0;
            wgt_req   <= 1'b0;
            pix_ready <= 1'b0;
            adder_rst <= 1'b0;
            out_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            img_w_q   <= img_w_nxt;
            img_h_q   <= img_h_nxt;
            groups_q  <= groups_nxt;
            scale_q   <= scale_nxt;
            col_q     <= col_nxt;
            row_q     <= row_nxt;
            group_q   <= group_nxt;
            drain_q   <= drain_nxt;
            bias_req  <= bias_req_d;
            wgt_req   <= wgt_req_d;
            pix_ready <= pix_ready_d;
            adder_rst <= adder_rst_d;
            out_en    <= out_en_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    assign current_state = state_q;
    assign scale_out     = scale_q;
    assign group_idx     = group_q;
    assign row_idx       = row_q;
    assign col_idx       = col_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Bench for conv_layer_sched: per-layer expected traces built from the layer rules, checked every cycle.
module tb_conv_layer_sched;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start, abort, bias_ack, wgt_ack, conv_valid_in;
    logic [8:0] cfg_img_w, cfg_img_h;
    logic [3:0] cfg_groups, cfg_scale;
    logic       bias_req, wgt_req, pix_ready, adder_rst, out_en, busy, done;
    logic [2:0] current_state;
    logic [3:0] scale_out, group_idx;
    logic [8:0] row_idx, col_idx;

    always #5 clk = ~clk;

    conv_layer_sched #(.W_WIDTH(9), .H_WIDTH(9), .G_WIDTH(4), .DRAIN_CYCLES(D)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .cfg_img_w(cfg_img_w), .cfg_img_h(cfg_img_h), .cfg_groups(cfg_groups), .cfg_scale(cfg_scale),
        .bias_req(bias_req), .bias_ack(bias_ack), .wgt_req(wgt_req), .wgt_ack(wgt_ack),
        .pix_ready(pix_ready), .conv_valid_in(conv_valid_in), .current_state(current_state),
        .adder_rst(adder_rst), .scale_out(scale_out), .out_en(out_en), .group_idx(group_idx),
        .row_idx(row_idx), .col_idx(col_idx), .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       breq, wreq, prdy, arst, oen, busy, done;
        logic [3:0] scale;
        logic [3:0] grp;
        logic [8:0] row;
        logic [8:0] col;
    } obs_t;

    typedef struct packed {
        logic       start, abort, back, wack, vld, rst;
        logic [8:0] w, h;
        logic [3:0] g, sc;
    } stim_t;

    obs_t  exp_q[$];
    stim_t stim_q[$];
    int m_scale = 0, m_grp = 0, m_row = 0, m_col = 0;
    int vectors = 0, errors = 0, cyc = 0;
    int n_busy, n_oen, n_arst, n_done, n_breq, n_wreq, n_prdy;

    // Expected outputs for a cycle in state st, from the model's current position.
    function automatic obs_t mk(logic [2:0] st, logic oen);
        obs_t e;
        e       = '0;
        e.st    = st;
        e.breq  = (st == 3'd1);
        e.wreq  = (st == 3'd2);
        e.prdy  = (st == 3'd3);
        e.oen   = oen;
        e.busy  = (st != 3'd0);
        e.done  = (st == 3'd5);
        e.scale = 4'(m_scale);
        if (st != 3'd0) begin
            e.grp = 4'(m_grp);
            e.row = 9'(m_row);
            e.col = 9'(m_col);
        end
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a.st = current_state; a.breq = bias_req; a.wreq = wgt_req; a.prdy = pix_ready;
        a.arst = adder_rst; a.oen = out_en; a.busy = busy; a.done = done;
        a.scale = scale_out; a.grp = group_idx; a.row = row_idx; a.col = col_idx;
        return a;
    endfunction

    task automatic push(input obs_t e, input stim_t s);
        exp_q.push_back(e);
        stim_q.push_back(s);
    endtask

    task automatic gen_idle(input int n);
        for (int i = 0; i < n; i++) push(mk(3'd0, 1'b0), '0);
    endtask

    task automatic gen_layer(input int w, input int h, input int g, input int sc,
                             input int blat, input int wlat, input bit gap, input bit hold,
                             input bit spur, input int abort_beat, input int rst_grp, input int rst_cyc);
        stim_t s;
        obs_t  e;
        int ew, eh, eg, b, k;
        bit oe;
        ew = (w == 0) ? 1 : w;
        eh = (h == 0) ? 1 : h;
        eg = (g == 0) ? 1 : g;
        s = '0; s.start = 1'b1; s.w = 9'(w); s.h = 9'(h); s.g = 4'(g); s.sc = 4'(sc);
        push(mk(3'd0, 1'b0), s);
        m_scale = sc; m_grp = 0; m_row = 0; m_col = 0;
        for (int i = 0; i < blat; i++) begin
            e = mk(3'd1, 1'b0); e.arst = (i == 0);
            s = '0; s.back = (i == blat - 1);
            push(e, s);
        end
        for (int gi = 0; gi < eg; gi++) begin
            m_grp = gi; m_row = 0; m_col = 0;
            oe = (gi == eg - 1);
            for (int i = 0; i < wlat; i++) begin
                s = '0; s.wack = (i == wlat - 1);
                if (gi == rst_grp && i == rst_cyc) begin
                    s.rst = 1'b1;
                    push(mk(3'd2, 1'b0), s);
                    m_scale = 0; m_grp = 0; m_row = 0; m_col = 0;
                    return;
                end
                push(mk(3'd2, 1'b0), s);
            end
            b = 0; k = 0;
            while (b < ew * eh) begin
                m_row = b / ew; m_col = b % ew;
                s = '0; s.vld = gap ? (k % 2 == 0) : 1'b1; s.wack = spur && (k == 1);
                if (b == abort_beat) begin
                    s.abort = 1'b1;
                    push(mk(3'd3, oe), s);
                    s = '0; s.start = 1'b1; s.abort = 1'b1; s.w = 9'(w); s.h = 9'(h);
                    s.g = 4'(g); s.sc = 4'(m_scale);
                    push(mk(3'd0, 1'b0), s);
                    return;
                end
                push(mk(3'd3, oe), s);
                if (s.vld) b++;
                k++;
            end
            m_row = eh; m_col = 0;
            for (int i = 0; i < D; i++) begin
                s = '0; s.vld = hold;
                push(mk(3'd4, oe), s);
            end
        end
        push(mk(3'd5, 1'b0), '0);
    endtask

    task automatic clear_cnt();
        n_busy = 0; n_oen = 0; n_arst = 0; n_done = 0; n_breq = 0; n_wreq = 0; n_prdy = 0;
    endtask

    task automatic lit(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic run_q();
        obs_t  e, a;
        stim_t s;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            s = stim_q.pop_front();
            @(posedge clk);
            #1;
            a = sample();
            if (!e.busy) begin
                a.grp = '0; a.row = '0; a.col = '0;
            end
            vectors++;
            if (a !== e) begin
                errors++;
                $display("FAIL trace cycle %0d: got %h expected %h (st,breq,wreq,prdy,arst,oen,busy,done,scale,grp,row,col)",
                         cyc, a, e);
            end
            n_busy += int'(a.busy); n_oen += int'(a.oen); n_arst += int'(a.arst);
            n_done += int'(a.done); n_breq += int'(a.breq); n_wreq += int'(a.wreq);
            n_prdy += int'(a.prdy);
            start = s.start; abort = s.abort; bias_ack = s.back; wgt_ack = s.wack;
            conv_valid_in = s.vld; cfg_img_w = s.w; cfg_img_h = s.h;
            cfg_groups = s.g; cfg_scale = s.sc;
            if (s.rst) begin
                #2 rstn = 1'b0;
                #1;
                a = sample();
                vectors++;
                if (a !== obs_t'('0)) begin
                    errors++;
                    $display("FAIL async reset cycle %0d: got %h expected 0", cyc, a);
                end
                #1 rstn = 1'b1;
            end
            cyc++;
        end
    endtask

    initial begin
        obs_t a;
        rstn = 1'b0; start = 1'b0; abort = 1'b0; bias_ack = 1'b0; wgt_ack = 1'b0;
        conv_valid_in = 1'b0; cfg_img_w = '0; cfg_img_h = '0; cfg_groups = '0; cfg_scale = '0;
        #2;
        a = sample();
        vectors++;
        if (a !== obs_t'('0)) begin
            errors++;
            $display("FAIL reset state: got %h expected 0", a);
        end
        #10 rstn = 1'b1;
        gen_idle(2);
        run_q();

        // Basic layer: 4x2, one group, acks on the second req cycle.
        clear_cnt(); gen_layer(4, 2, 1, 3, 2, 2, 0, 0, 0, -1, -1, -1); run_q();
        lit("basic busy", n_busy, 17); lit("basic out_en", n_oen, 12);
        lit("basic adder_rst", n_arst, 1); lit("basic done", n_done, 1);

        clear_cnt(); gen_layer(3, 3, 3, 5, 1, 1, 0, 0, 0, -1, -1, -1); run_q();
        lit("multi busy", n_busy, 44); lit("multi wgt_req", n_wreq, 3);
        lit("multi bias_req", n_breq, 1); lit("multi out_en", n_oen, 13);
        lit("multi adder_rst", n_arst, 1);

        clear_cnt(); gen_layer(5, 1, 1, 1, 1, 1, 1, 1, 0, -1, -1, -1); run_q();
        lit("gapped pix_ready", n_prdy, 9); lit("gapped busy", n_busy, 16);

        clear_cnt(); gen_layer(2, 2, 2, 7, 7, 3, 0, 0, 1, -1, -1, -1); run_q();
        lit("delayed bias_req", n_breq, 7); lit("delayed wgt_req", n_wreq, 6);
        lit("delayed busy", n_busy, 30);

        clear_cnt(); gen_layer(4, 2, 1, 2, 1, 1, 0, 0, 0, 5, -1, -1); run_q();
        lit("abort busy", n_busy, 8); lit("abort done", n_done, 0);

        clear_cnt(); gen_layer(4, 2, 1, 3, 2, 2, 0, 0, 0, -1, -1, -1); run_q();
        lit("after abort busy", n_busy, 17); lit("after abort done", n_done, 1);

        clear_cnt(); gen_layer(3, 2, 2, 9, 1, 3, 0, 0, 0, -1, 1, 1); run_q();
        lit("reset busy", n_busy, 16); lit("reset done", n_done, 0);

        clear_cnt(); gen_layer(4, 2, 1, 3, 2, 2, 0, 0, 0, -1, -1, -1); run_q();
        lit("after reset busy", n_busy, 17); lit("after reset done", n_done, 1);

        clear_cnt(); gen_layer(0, 0, 0, 0, 1, 1, 0, 0, 0, -1, -1, -1); run_q();
        lit("zero busy", n_busy, 8); lit("zero pix_ready", n_prdy, 1);
        lit("zero out_en", n_oen, 5); lit("zero done", n_done, 1);

        gen_idle(2);
        run_q();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/conv_layer_sched.md
Name: conv_layer_sched

Overview:
- Per-layer sequencer for the convolution unit: NPU array plus its local controller.
- On start it latches the layer geometry, fetches bias once, then loops over input-channel groups. Each group: fetch weights, stream one feature map of pixels, drain the multiplier/adder pipeline.
- Drives the unit's 3-bit current_state, the accumulator clear, the scale value and the output enable.
- Sits between the layer-level DMA/feeder and the convolution unit.

Parameters:
- W_WIDTH, 9, width of image width and column counter (max 511; 320 nominal).
- H_WIDTH, 9, width of image height and row counter.
- G_WIDTH, 4, width of group count and group index.
- DRAIN_CYCLES, 4, cycles spent in DRAIN after the last pixel of a group (covers multiplier stages plus adder tree); must be >= 1.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run a layer; honoured only in IDLE.
- abort  in  1  synchronous abort; forces IDLE on the next edge from any state.
- cfg_img_w  in  W_WIDTH  pixels per row; 0 treated as 1.
- cfg_img_h  in  H_WIDTH  rows per frame; 0 treated as 1.
- cfg_groups  in  G_WIDTH  input-channel groups; 0 treated as 1.
- cfg_scale  in  4  requantisation shift.
- bias_req  out  1  bias fetch request.
- bias_ack  in  1  bias loaded.
- wgt_req  out  1  weight fetch request.
- wgt_ack  in  1  weight set loaded.
- pix_ready  out  1  feeder may present pixels.
- conv_valid_in  in  1  pixel beat accepted by the convolution unit.
- current_state  out  3  state code to the convolution unit.
- adder_rst  out  1  accumulator clear pulse.
- scale_out  out  4  latched cfg_scale.
- out_en  out  1  final-group output enable.
- group_idx  out  G_WIDTH  current group.
- row_idx  out  H_WIDTH  current row.
- col_idx  out  W_WIDTH  current column.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rstn low, asynchronous):
  - All outputs 0, current_state=IDLE, counters 0, latched config 0.
  - Reset mid-operation abandons the layer; no done is issued.
- All outputs are registered.
- States and current_state codes: IDLE=0, LOAD_BIAS=1, LOAD_WGT=2, CONV=3, DRAIN=4, DONE=5. Codes 6-7 are unused; if reached, go to IDLE.
- IDLE:
  - start=1 latches cfg_* (with the 0->1 substitution) and scale_out, clears the counters, then enters LOAD_BIAS.
  - adder_rst pulses high for exactly the first LOAD_BIAS cycle.
  - start is ignored in every other state.
- LOAD_BIAS:
  - bias_req=1 until bias_ack is sampled high; bias_req is 0 on the next cycle, which is also the first cycle of LOAD_WGT.
- LOAD_WGT:
  - Same handshake using wgt_req/wgt_ack, then CONV.
  - An ack seen while the matching req is 0 is ignored.
- CONV:
  - pix_ready=1.
  - Each cycle with conv_valid_in=1 advances col_idx. When col_idx=img_w-1 it wraps to 0 and row_idx increments.
  - When the beat at (img_h-1, img_w-1) is accepted, the next state is DRAIN and pix_ready=0 from that cycle on.
  - conv_valid_in while pix_ready=0 is ignored and does not advance the counters.
- DRAIN:
  - Lasts exactly DRAIN_CYCLES cycles.
  - On exit, if group_idx=groups-1 go to DONE. Otherwise increment group_idx, clear row/col, and go to LOAD_WGT. Bias is not refetched and adder_rst is not pulsed, so the unit accumulates across groups.
- out_en=1 throughout CONV and DRAIN of the last group only.
- DONE: done=1 for one cycle, then IDLE.
- Simultaneous events:
  - abort has priority over every transition and handshake: req outputs drop on the next cycle and no done pulse is issued.
  - abort together with start in IDLE: stay in IDLE.
- The state machine accepts no new start until it has returned to IDLE; the earliest possible restart is the cycle after done.
- Minimum layer latency with immediate acks: 1 (bias) + groups*(1 + w*h + DRAIN_CYCLES) + 1 (done) cycles from the first LOAD_BIAS cycle.

Test Plan:
- Basic layer: w=4, h=2, groups=1, scale=3, acks returned 1 cycle after req, pixels every cycle.
  - Expect state sequence 1,2,3 (8 beats), 4 (4 cycles), 5, 0.
  - Expect scale_out=3, out_en high for 12 cycles, one adder_rst and one done pulse.
- Multi-group: w=3, h=3, groups=3.
  - Expect 1 bias_req and 3 wgt_req handshakes.
  - group_idx steps 0->1->2; adder_rst fires once; out_en only during group 2.
- Gapped pixels: w=5, h=1, conv_valid_in toggling 1010...
  - col_idx advances only on valid beats; DRAIN entered after the 5th accepted beat.
  - A valid beat held during DRAIN does not change the counters.
- Delayed acks: bias_ack after 7 cycles, wgt_ack after 3 cycles.
  - Each req is held for exactly that long and is 0 the cycle after its ack.
  - A spurious wgt_ack in CONV is ignored.
- Abort/reset:
  - abort in CONV at pixel 5 -> IDLE next cycle, no done, busy=0.
  - rstn low mid-LOAD_WGT -> all outputs 0 immediately.
  - A following start runs a full layer correctly.
- Zero config: w=0, h=0, groups=0 -> behaves as 1x1 with one group, i.e. one pixel beat, then DRAIN, then done.
